// File: rtl/contador_ascendente.sv
// Modulo-Maximacuenta up-counter with clock enable: counts 0..Maximacuenta-1 and
// wraps to 0. The count register drives the output directly.
module contador_ascendente #(
  parameter  int Maximacuenta = 28,
  localparam int W = (Maximacuenta < 2) ? 1 : $clog2(Maximacuenta)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [W-1:0] count
);

  // A modulus below 2 leaves nothing to count.
  if (Maximacuenta < 2) begin : g_bad_modulus
    $error("contador_ascendente: Maximacuenta must be >= 2");
  end

  localparam logic [W-1:0] LAST = W'(Maximacuenta - 1);

  // Explicit terminal compare keeps values >= Maximacuenta unreachable for
  // non-power-of-two moduli.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_contador_ascendente.sv
// Bench for contador_ascendente: table-driven vectors on the default modulus, hand
// sequences for reset priority and wrap, and random stimulus vs. a modulo model.
module tb_contador_ascendente;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [4:0] count28;
  logic [4:0] count32;
  logic [0:0] count2;

  int total = 0;
  int bad   = 0;

  // Reference state: plain modulo arithmetic per instance.
  int m28, m32, m2;
  logic [4:0] exp_q28[$];
  logic [4:0] exp_q32[$];
  logic [0:0] exp_q2[$];

  typedef struct {
    logic rst;
    logic en;
    int   exp;
  } vec_t;
  vec_t vecs[$];

  contador_ascendente #(.Maximacuenta(28)) dut28 (
    .clk(clk), .rst(rst), .enable(enable), .count(count28)
  );
  contador_ascendente #(.Maximacuenta(32)) dut32 (
    .clk(clk), .rst(rst), .enable(enable), .count(count32)
  );
  contador_ascendente #(.Maximacuenta(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .count(count2)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
  end

  task automatic compare(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_sb();
    logic [4:0] e28, e32;
    logic [0:0] e2;
    e28 = exp_q28.pop_front();
    e32 = exp_q32.pop_front();
    e2  = exp_q2.pop_front();
    compare("model_m28", int'(count28), int'(e28));
    compare("model_m32", int'(count32), int'(e32));
    compare("model_m2",  int'(count2),  int'(e2));
    compare("range_m28", int'(count28 < 5'd28), 1);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit after
  // the rising edge.
  task automatic drive(input logic r, input logic e);
    @(negedge clk);
    rst    = r;
    enable = e;
    @(posedge clk);
    if (r) begin
      m28 = 0; m32 = 0; m2 = 0;
    end else if (e) begin
      m28 = (m28 + 1) % 28;
      m32 = (m32 + 1) % 32;
      m2  = (m2 + 1) % 2;
    end
    exp_q28.push_back(5'(m28));
    exp_q32.push_back(5'(m32));
    exp_q2.push_back(1'(m2));
    #1;
    check_sb();
  endtask

  function automatic void add(input logic r, input logic e, input int x);
    vec_t v;
    v.rst = r;
    v.en  = e;
    v.exp = x;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    logic r, e;
    m28 = 0; m32 = 0; m2 = 0;

    // Reset then free count through two wraps (60 edges).
    add(1'b1, 1'b1, 0);
    for (int i = 1; i <= 60; i++) add(1'b0, 1'b1, i % 28);
    // Enable gating at 10.
    add(1'b1, 1'b0, 0);
    for (int i = 1; i <= 10; i++) add(1'b0, 1'b1, i);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 10);
    add(1'b0, 1'b1, 11);
    // Hold at terminal value, then re-enable wraps.
    for (int i = 12; i <= 27; i++) add(1'b0, 1'b1, i);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 27);
    add(1'b0, 1'b1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en);
      compare($sformatf("vec%0d", i), int'(count28), vecs[i].exp);
    end

    // Reset priority mid-count.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1);
    compare("pri_at15", int'(count28), 15);
    drive(1'b1, 1'b1);
    compare("pri_rst", int'(count28), 0);
    drive(1'b0, 1'b1);
    compare("pri_resume", int'(count28), 1);

    // Power-of-two and minimum moduli.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) drive(1'b0, 1'b1);
    compare("pow2_top", int'(count32), 31);
    compare("min_odd", int'(count2), 1);
    compare("m28_at31", int'(count28), 3);
    drive(1'b0, 1'b1);
    compare("pow2_wrap", int'(count32), 0);
    compare("min_wrap", int'(count2), 0);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 39);
      r = (n == 0);
      e = ($urandom_range(0, 9) < 7);
      drive(r, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
